// File: rtl/timer_regressivo_pkg.sv
// ============================================================================
// Module  : timer_pkg
// Brief   : Shared state encoding and sizing helper for timer_regressivo.
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2,
        EXPIRADO = 2'd3
    } estado_t;

    // Prescaler counter width; never narrower than one bit (P=1 still needs a register).
    function automatic int prescaler_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_regressivo_divisor_tick.sv
// ============================================================================
// Module  : divisor_tick
// Brief   : Prescaler counting 0..P-1 while enabled; tick marks the wrap.
// Revision: 1.0
// ============================================================================
`default_nettype none

module divisor_tick #(
    parameter int P = 50_000_000,
    parameter int W = 26
) (
    input  logic clock,
    input  logic zera_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [W-1:0] c_max = W'(P - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_max) ? '0 : r_cnt + W'(1);
        end
    end

    assign tick = en && (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/timer_regressivo.sv
// ============================================================================
// Module  : timer_regressivo
// Brief   : Loadable countdown timer with pause, expiry pulse and level.
//           Optional half-count pulse `meio` when TIMER_REGRESSIVO_MEIO_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_regressivo
    import timer_pkg::*;
#(
    parameter int M = 100,
    parameter int N = 7,
    parameter int P = 50_000_000
) (
    input  logic         clock,
    input  logic         zera_n,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         inicia,
    input  logic         pausa,
    output logic [N-1:0] Q,
    output logic         ativo,
    output logic         fim,
    output logic         expirado
`ifdef TIMER_REGRESSIVO_MEIO_EN
    ,
    output logic         meio
`endif
);

    localparam int           c_pw  = prescaler_width(P);
    localparam logic [N-1:0] c_max = N'(M - 1);

    estado_t      r_estado;
    logic         w_tick;
    logic         w_clr;
    logic         w_en;
    logic [N-1:0] w_carga;
    logic [N-1:0] w_q_dec;

    assign w_carga = (int'(valor) > M - 1) ? c_max : valor;
    assign w_q_dec = Q - N'(1);
    assign w_clr   = zera_s | carrega;
    // Prescaler holds through a pause so a resumed period keeps its progress.
    assign w_en    = (r_estado == CONTANDO) && !zera_s && !carrega && !pausa;

    divisor_tick #(
        .P (P),
        .W (c_pw)
    ) u_divisor_tick (
        .clock  (clock),
        .zera_n (zera_n),
        .clr    (w_clr),
        .en     (w_en),
        .tick   (w_tick)
    );

`ifdef TIMER_REGRESSIVO_MEIO_EN
    logic [N-1:0] r_l;
    logic [N-1:0] w_metade;

    assign w_metade = r_l >> 1;

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            r_l  <= '0;
            meio <= 1'b0;
        end else begin
            meio <= 1'b0;
            if (zera_s) begin
                r_l <= '0;
            end else if (carrega) begin
                r_l <= w_carga;
            end else if (w_tick && (w_q_dec == w_metade) && (w_metade != '0)) begin
                meio <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clock or negedge zera_n) begin
        if (!zera_n) begin
            r_estado <= OCIOSO;
            Q        <= '0;
            ativo    <= 1'b0;
            fim      <= 1'b0;
            expirado <= 1'b0;
        end else begin
            fim <= 1'b0;
            if (zera_s) begin
                r_estado <= OCIOSO;
                Q        <= '0;
                ativo    <= 1'b0;
                expirado <= 1'b0;
            end else if (carrega) begin
                r_estado <= OCIOSO;
                Q        <= w_carga;
                ativo    <= 1'b0;
                expirado <= 1'b0;
            end else begin
                case (r_estado)
                    OCIOSO, PAUSADO: begin
                        if (inicia) begin
                            if (Q != '0) begin
                                r_estado <= CONTANDO;
                                ativo    <= 1'b1;
                            end else begin
                                r_estado <= EXPIRADO;
                                ativo    <= 1'b0;
                                expirado <= 1'b1;
                                fim      <= 1'b1;
                            end
                        end
                    end
                    CONTANDO: begin
                        if (pausa) begin
                            r_estado <= PAUSADO;
                        end else if (w_tick) begin
                            Q <= w_q_dec;
                            if (Q == N'(1)) begin
                                r_estado <= EXPIRADO;
                                ativo    <= 1'b0;
                                expirado <= 1'b1;
                                fim      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_regressivo.sv
// ============================================================================
// Module  : tb_timer_regressivo
// Brief   : Directed self-checking bench for timer_regressivo (P=4, M=100).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer_regressivo;

    localparam int c_m = 100;
    localparam int c_n = 7;
    localparam int c_p = 4;

    logic           clock = 1'b0;
    logic           zera_n = 1'b0;
    logic           zera_s = 1'b0;
    logic           carrega = 1'b0;
    logic [c_n-1:0] valor = '0;
    logic           inicia = 1'b0;
    logic           pausa = 1'b0;
    logic [c_n-1:0] Q;
    logic           ativo;
    logic           fim;
    logic           expirado;
`ifdef TIMER_REGRESSIVO_MEIO_EN
    logic           meio;
`endif

    int checks = 0;
    int failures = 0;

    timer_regressivo #(
        .M (c_m),
        .N (c_n),
        .P (c_p)
    ) dut (
        .clock    (clock),
        .zera_n   (zera_n),
        .zera_s   (zera_s),
        .carrega  (carrega),
        .valor    (valor),
        .inicia   (inicia),
        .pausa    (pausa),
        .Q        (Q),
        .ativo    (ativo),
        .fim      (fim),
        .expirado (expirado)
`ifdef TIMER_REGRESSIVO_MEIO_EN
        ,
        .meio     (meio)
`endif
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int v);
        valor = c_n'(v);
        carrega = 1'b1;
        cyc(1);
        carrega = 1'b0;
    endtask

    task automatic start();
        inicia = 1'b1;
        cyc(1);
        inicia = 1'b0;
    endtask

    initial begin
`ifdef TIMER_REGRESSIVO_MEIO_EN
        int pulses;
        int q_at_pulse;
`endif
        cyc(2);
        zera_n = 1'b1;
        cyc(1);
        chk("reset_q", int'(Q), 0);
        chk("reset_ativo", int'(ativo), 0);
        chk("reset_fim", int'(fim), 0);
        chk("reset_expirado", int'(expirado), 0);

        // Asynchronous reset in the middle of a count
        load(50);
        start();
        chk("run_ativo", int'(ativo), 1);
        cyc(4);
        chk("run_q49", int'(Q), 49);
        #2 zera_n = 1'b0;
        #1;
        chk("async_q", int'(Q), 0);
        chk("async_ativo", int'(ativo), 0);
        cyc(1);
        chk("async_hold_expirado", int'(expirado), 0);
        zera_n = 1'b1;
        cyc(1);

        // Basic count from 3
        load(3);
        chk("load3_q", int'(Q), 3);
        chk("load3_ativo", int'(ativo), 0);
        start();
        chk("start_q", int'(Q), 3);
        chk("start_ativo", int'(ativo), 1);
        cyc(3);
        chk("pre_tick_q", int'(Q), 3);
        cyc(1);
        chk("tick1_q", int'(Q), 2);
        cyc(4);
        chk("tick2_q", int'(Q), 1);
        chk("tick2_fim", int'(fim), 0);
        cyc(4);
        chk("tick3_q", int'(Q), 0);
        chk("tick3_fim", int'(fim), 1);
        chk("tick3_expirado", int'(expirado), 1);
        chk("tick3_ativo", int'(ativo), 0);
        cyc(1);
        chk("after_fim", int'(fim), 0);
        chk("after_expirado", int'(expirado), 1);
        cyc(5);
        chk("hold_q", int'(Q), 0);
        chk("hold_expirado", int'(expirado), 1);

        // Clamp and zero start
        load(120);
        chk("clamp_q", int'(Q), 99);
        chk("clamp_expirado", int'(expirado), 0);
        load(0);
        chk("zero_q", int'(Q), 0);
        start();
        chk("zero_fim", int'(fim), 1);
        chk("zero_expirado", int'(expirado), 1);
        cyc(1);
        chk("zero_fim_drop", int'(fim), 0);

        // Pause with two cycles of progress, then resume
        load(5);
        start();
        cyc(2);
        pausa = 1'b1;
        cyc(1);
        chk("pause_q", int'(Q), 5);
        chk("pause_ativo", int'(ativo), 1);
        cyc(9);
        chk("pause_hold_q", int'(Q), 5);
        pausa = 1'b0;
        cyc(2);
        chk("no_auto_resume_q", int'(Q), 5);
        start();
        chk("resume0_q", int'(Q), 5);
        cyc(1);
        chk("resume1_q", int'(Q), 5);
        cyc(1);
        chk("resume2_q", int'(Q), 4);

        // Load collides with a tick at Q=2
        load(3);
        start();
        cyc(4);
        chk("coll_pre_q", int'(Q), 2);
        cyc(3);
        valor = 7'd7;
        carrega = 1'b1;
        cyc(1);
        carrega = 1'b0;
        chk("coll_q", int'(Q), 7);
        chk("coll_ativo", int'(ativo), 0);
        cyc(6);
        chk("coll_idle_q", int'(Q), 7);

        // Synchronous clear mid-count
        load(40);
        start();
        cyc(2);
        chk("clr_pre_q", int'(Q), 40);
        zera_s = 1'b1;
        cyc(1);
        zera_s = 1'b0;
        chk("clr_q", int'(Q), 0);
        chk("clr_ativo", int'(ativo), 0);
        chk("clr_fim", int'(fim), 0);

`ifdef TIMER_REGRESSIVO_MEIO_EN
        load(9);
        start();
        pulses = 0;
        q_at_pulse = -1;
        for (int i = 0; i < 45; i++) begin
            cyc(1);
            if (meio) begin
                pulses++;
                q_at_pulse = int'(Q);
            end
        end
        chk("meio9_pulses", pulses, 1);
        chk("meio9_q", q_at_pulse, 4);
        load(1);
        start();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (meio) pulses++;
        end
        chk("meio1_pulses", pulses, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_regressivo.md
# timer_regressivo

Loadable countdown timer. A value is loaded, decremented once per prescaled tick while running, and the timer flags expiry when it reaches zero. It is the down-counting counterpart to the modulo-M up counter. Game-phase logic uses it for round and vote time limits, and the 7-segment path reads `Q` for display.

## Interface
- `M`, default 100: counter modulus; loaded values are clamped to M-1.
- `N`, default 7: width of `Q` and `valor`; requires 2^N ≥ M.
- `P`, default 50_000_000: clock cycles per tick (1 s at 50 MHz); requires P ≥ 1.
- `clock` in 1: single clock, rising edge.
- `zera_n` in 1: reset, asynchronous, active-low.
- `zera_s` in 1: synchronous clear to OCIOSO.
- `carrega` in 1: load `valor` into `Q`.
- `valor` in N: value to load.
- `inicia` in 1: start or resume counting.
- `pausa` in 1: level; while high, counting is held.
- `Q` out N: current count.
- `ativo` out 1: high in CONTANDO and PAUSADO.
- `fim` out 1: one-cycle pulse on expiry.
- `expirado` out 1: level, high in state EXPIRADO.

## Operation
- States:
  - OCIOSO (reset)
  - CONTANDO
  - PAUSADO
  - EXPIRADO
- Command priority, highest first: `zera_s` > `carrega` > `inicia` > `pausa`.
- `zera_s`: Q=0, prescaler=0, next state OCIOSO. Valid from any state.
- `carrega`: Q=min(valor, M-1), prescaler=0, next state OCIOSO. Valid from any state, including mid-count.
- `inicia`:
  - From OCIOSO or PAUSADO with Q>0: go to CONTANDO.
  - With Q==0: go to EXPIRADO and pulse `fim`.
  - Ignored in CONTANDO and EXPIRADO.
- In CONTANDO:
  - `pausa`=1 moves to PAUSADO. The prescaler holds its value, so a resumed tick keeps its partial period.
  - Otherwise the prescaler counts 0..P-1. When it wraps, a tick occurs and Q decrements.
  - A tick with Q==1 sets Q=0, moves to EXPIRADO and pulses `fim`.
- In PAUSADO, `pausa`=0 alone does not resume; `inicia` is required.
- EXPIRADO holds Q=0 until `carrega` or `zera_s`.
- Q never wraps below 0. Decrement logic is N bits wide and unsigned.

## Timing
- Reset values: Q=0, `ativo`=0, `fim`=0, `expirado`=0, prescaler=0, state OCIOSO.
- All outputs are registered. They change only on the rising edge of `clock`, or on assertion of `zera_n`.
- The first decrement occurs P cycles after the edge that samples `inicia`. Each later decrement follows P cycles after the previous one.
- `fim` is high for exactly the one cycle in which Q first reads 0. `expirado` rises on that same edge.
- If `carrega` and a tick fall on the same edge, the load wins and no decrement happens.
- If `pausa` and a tick fall on the same edge, pause wins and Q is unchanged.
- With P=1, Q decrements on every cycle spent in CONTANDO.
- `zera_n` asserted mid-count returns all outputs to reset values immediately. The timer leaves reset on the first edge after release.

## Configuration
- `TIMER_REGRESSIVO_MEIO_EN` defined:
  - Adds output `meio` (1 bit, registered, reset 0).
  - `meio` pulses for one cycle when Q decrements to floor(L/2), where L is the last loaded value.
  - L is stored in an extra N-bit register. No pulse if floor(L/2)==0.
- Undefined: no `meio` port and no L register. All other behaviour is identical.

## Structure
- Package `timer_pkg` holds:
  - State enumeration: OCIOSO=2'd0, CONTANDO=2'd1, PAUSADO=2'd2, EXPIRADO=2'd3.
  - Helper constant for prescaler width, $clog2(P) (min 1).
- Sub-module `divisor_tick` is the prescaler, with ports:
  - inputs: clock, zera_n, clr, en
  - output: tick
- `tick` is combinational and high when the count equals P-1 and `en`=1.
- The state machine and Q register stay in `timer_regressivo`.

## Test plan
- **Reset and basic count:** P=4, M=100. Assert `zera_n`=0 mid-run, then release. Load 3 and `inicia`.
  - While `zera_n`=0: all outputs are 0.
  - After start: Q reads 3,2,1,0 at 4-cycle spacing.
  - `fim` is high only in the cycle Q=0, and `expirado` stays high afterwards.
- **Clamp and zero start:** load 120 with M=100 gives Q=99. Load 0, then `inicia`: next cycle `fim`=1 and `expirado`=1.
- **Pause and resume:** P=4, load 5, start. Raise `pausa` 2 cycles into a period for 10 cycles, then lower it and pulse `inicia`. Q stays 5 during the pause, then reaches 4 two cycles after the resume.
- **Priority collision:** `carrega` (valor=7) on the same edge as a tick with Q=2. Result is Q=7, state OCIOSO, `ativo`=0.
- **Sync clear mid-count:** `zera_s` with Q=40 in CONTANDO. Next cycle Q=0, `ativo`=0, `fim`=0.
- **Half-count pulse (`TIMER_REGRESSIVO_MEIO_EN` defined):** load 9, start. `meio` pulses once, when Q=4. Load 1, start: `meio` never pulses.
